// File: rtl/rv32i_mc_ctrl.sv
// rv32i_mc_ctrl: multi-cycle RV32I control FSM sequencing fetch, decode, execute,
// data-memory access and write-back strobes for an external ALU/register-file datapath.
module rv32i_mc_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter bit          ILLEGAL_TRAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    input  logic        dmem_ack_i,
    output logic [4:0]  alu_ctrl_o,
    output logic [1:0]  alu_a_sel_o,
    output logic        alu_b_imm_o,
    input  logic        alu_zero_i,
    input  logic        alu_lsb_i,
    output logic        reg_we_o,
    output logic [1:0]  wb_sel_o,
    output logic        pc_we_o,
    output logic        pc_sel_o,
    output logic [31:0] instr_out_o,
    output logic        illegal_o
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BR, S_TRAP} state_e;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        illegal_q, illegal_d;
    logic        taken_q, taken_d;
    logic [4:0]  alu_op;
    logic [1:0]  a_sel;
    logic        b_imm, br_taken;
    logic        unused_reset_pc;

    // The PC register lives in the datapath; its reset value is carried here for integration only.
    assign unused_reset_pc = ^RESET_PC;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       f7b;
    assign opcode = instr_q[6:0];
    assign f3     = instr_q[14:12];
    assign f7b    = instr_q[30];

    logic is_op, is_opimm, is_load, is_store, is_lui, is_auipc, is_branch, is_jal, is_jalr, valid;
    assign is_op     = opcode == 7'b0110011;
    assign is_opimm  = opcode == 7'b0010011;
    assign is_load   = opcode == 7'b0000011;
    assign is_store  = opcode == 7'b0100011;
    assign is_lui    = opcode == 7'b0110111;
    assign is_auipc  = opcode == 7'b0010111;
    assign is_branch = opcode == 7'b1100011;
    assign is_jal    = opcode == 7'b1101111;
    assign is_jalr   = opcode == 7'b1100111;
    assign valid     = is_op | is_opimm | is_load | is_store | is_lui | is_auipc | is_branch | is_jal | is_jalr;

    always_comb begin
        case (f3)
            3'b000:  alu_op = is_op ? (f7b ? 5'd9 : 5'd1) : 5'd2;
            3'b001:  alu_op = is_op ? 5'd17 : 5'd14;
            3'b010:  alu_op = is_op ? 5'd10 : 5'd11;
            3'b011:  alu_op = is_op ? 5'd12 : 5'd13;
            3'b100:  alu_op = is_op ? 5'd5 : 5'd6;
            3'b101:  alu_op = is_op ? (f7b ? 5'd19 : 5'd18) : (f7b ? 5'd16 : 5'd15);
            3'b110:  alu_op = is_op ? 5'd3 : 5'd4;
            default: alu_op = is_op ? 5'd7 : 5'd8;
        endcase
        if (is_branch)
            alu_op = f3[2] ? (f3[1] ? 5'd12 : 5'd10) : 5'd9;
        else if (!(is_op || is_opimm))
            alu_op = valid ? 5'd2 : 5'd0;
    end

    assign a_sel = is_lui ? 2'd2 : ((is_auipc || is_jal) ? 2'd1 : 2'd0);
    assign b_imm = valid && !is_op && !is_branch;
    // funct3[0] inverts the sense: BNE/BGE/BGEU; funct3 010/011 never branch.
    assign br_taken = f3[2] ? (alu_lsb_i ^ f3[0]) : (!f3[1] && (alu_zero_i ^ f3[0]));

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        illegal_d   = illegal_q;
        taken_d     = taken_q;
        imem_req_o  = 1'b0;
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        alu_ctrl_o  = 5'd0;
        alu_a_sel_o = 2'd0;
        alu_b_imm_o = 1'b0;
        reg_we_o    = 1'b0;
        wb_sel_o    = 2'd0;
        pc_we_o     = 1'b0;
        pc_sel_o    = 1'b0;
        // ALU controls stay valid through MEM and WB so address/target remain stable.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            alu_ctrl_o  = alu_op;
            alu_a_sel_o = a_sel;
            alu_b_imm_o = b_imm;
        end
        case (state_q)
            S_FETCH: begin
                imem_req_o = rst_n;
                if (imem_ack_i) begin
                    instr_d = imem_rdata_i;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (valid) state_d = S_EXEC;
                else begin
                    illegal_d = 1'b1;
                    state_d   = ILLEGAL_TRAP ? S_TRAP : S_WB;
                end
            end
            S_EXEC: begin
                taken_d = br_taken;
                state_d = is_branch ? S_BR : ((is_load || is_store) ? S_MEM : S_WB);
            end
            S_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = is_store;
                if (dmem_ack_i) state_d = S_WB;
            end
            S_WB: begin
                reg_we_o = valid && !is_store && !is_branch && (instr_q[11:7] != 5'd0);
                wb_sel_o = (is_jal || is_jalr) ? 2'd2 : (is_load ? 2'd1 : 2'd0);
                pc_we_o  = 1'b1;
                pc_sel_o = is_jal || is_jalr;
                state_d  = S_FETCH;
            end
            S_BR: begin
                alu_ctrl_o  = 5'd2;
                alu_a_sel_o = 2'd1;
                alu_b_imm_o = 1'b1;
                pc_we_o     = 1'b1;
                pc_sel_o    = taken_q;
                state_d     = S_FETCH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            instr_q   <= 32'd0;
            illegal_q <= 1'b0;
            taken_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            illegal_q <= illegal_d;
            taken_q   <= taken_d;
        end
    end

    assign instr_out_o = instr_q;
    assign illegal_o   = illegal_q;
endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// tb_rv32i_mc_ctrl: directed self-checking bench for the multi-cycle RV32I control FSM.
module tb_rv32i_mc_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_o, imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        dmem_req_o, dmem_we_o, dmem_ack_i;
    logic [4:0]  alu_ctrl_o;
    logic [1:0]  alu_a_sel_o;
    logic        alu_b_imm_o, alu_zero_i, alu_lsb_i;
    logic        reg_we_o;
    logic [1:0]  wb_sel_o;
    logic        pc_we_o, pc_sel_o;
    logic [31:0] instr_out_o;
    logic        illegal_o;
    int          checks = 0;
    int          failures = 0;

    rv32i_mc_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_o(imem_req_o), .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i),
        .alu_ctrl_o(alu_ctrl_o), .alu_a_sel_o(alu_a_sel_o), .alu_b_imm_o(alu_b_imm_o),
        .alu_zero_i(alu_zero_i), .alu_lsb_i(alu_lsb_i),
        .reg_we_o(reg_we_o), .wb_sel_o(wb_sel_o), .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o),
        .instr_out_o(instr_out_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Zero-wait fetch from FETCH; returns at the negedge of the state after DECODE.
    task automatic fetch(input logic [31:0] ins);
        check("fetch_req", imem_req_o, 1);
        imem_ack_i   = 1'b1;
        imem_rdata_i = ins;
        step();
        imem_ack_i   = 1'b0;
        imem_rdata_i = 32'hDEAD_BEEF;
        check("decode_instr", instr_out_o, ins);
        check("decode_req", imem_req_o, 0);
        step();
    endtask

    task automatic exec(input logic [4:0] alu, input logic [1:0] asel, input logic bimm);
        check("exec_alu", alu_ctrl_o, alu);
        check("exec_asel", alu_a_sel_o, asel);
        check("exec_bimm", alu_b_imm_o, bimm);
        check("exec_strobes", {reg_we_o, pc_we_o, imem_req_o, dmem_req_o}, 0);
    endtask

    task automatic wb(input logic rwe, input logic [1:0] wsel, input logic psel);
        check("wb_reg_we", reg_we_o, rwe);
        check("wb_sel", wb_sel_o, wsel);
        check("wb_pc_we", pc_we_o, 1);
        check("wb_pc_sel", pc_sel_o, psel);
        check("wb_no_req", {imem_req_o, dmem_req_o}, 0);
        step();
        check("back_fetch", {imem_req_o, pc_we_o, reg_we_o}, 3'b100);
    endtask

    initial begin
        rst_n = 1'b0; imem_ack_i = 1'b0; imem_rdata_i = 32'd0; dmem_ack_i = 1'b0;
        alu_zero_i = 1'b0; alu_lsb_i = 1'b0;
        step();
        check("rst_outs", {imem_req_o, dmem_req_o, dmem_we_o, reg_we_o, pc_we_o, pc_sel_o, illegal_o}, 0);
        check("rst_alu", {alu_ctrl_o, alu_a_sel_o, alu_b_imm_o, wb_sel_o}, 0);
        check("rst_instr", instr_out_o, 0);
        rst_n = 1'b1;
        #1;
        // ADD x3,x1,x2: 4 cycles
        fetch(32'h002081B3);
        exec(5'd1, 2'd0, 1'b0);
        step();
        wb(1'b1, 2'd0, 1'b0);
        // SRAI x5,x5,3
        fetch(32'h4032D293);
        exec(5'd16, 2'd0, 1'b1);
        step();
        wb(1'b1, 2'd0, 1'b0);
        // SUB x1,x2,x3
        fetch(32'h403100B3);
        exec(5'd9, 2'd0, 1'b0);
        step();
        wb(1'b1, 2'd0, 1'b0);
        // LW x4,8(x1) with ack on the third MEM cycle
        fetch(32'h0080A203);
        exec(5'd2, 2'd0, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            check("lw_mem_req", dmem_req_o, 1);
            check("lw_mem_we", dmem_we_o, 0);
            check("lw_mem_alu", {alu_ctrl_o, alu_a_sel_o, alu_b_imm_o}, {5'd2, 2'd0, 1'b1});
            check("lw_mem_strobes", {reg_we_o, pc_we_o}, 0);
            if (i == 2) dmem_ack_i = 1'b1;
            step();
        end
        dmem_ack_i = 1'b0;
        wb(1'b1, 2'd1, 1'b0);
        // SW x2,4(x1) zero-wait
        fetch(32'h0020A223);
        exec(5'd2, 2'd0, 1'b1);
        step();
        check("sw_mem", {dmem_req_o, dmem_we_o}, 2'b11);
        dmem_ack_i = 1'b1;
        step();
        dmem_ack_i = 1'b0;
        wb(1'b0, 2'd0, 1'b0);
        // BEQ taken then not taken, BLTU taken
        for (int i = 0; i < 3; i++) begin
            fetch(i == 2 ? 32'h0020E463 : 32'h00208463);
            exec(i == 2 ? 5'd12 : 5'd9, 2'd0, 1'b0);
            alu_zero_i = (i == 0);
            alu_lsb_i  = (i == 2);
            step();
            alu_zero_i = 1'b0; alu_lsb_i = 1'b0;
            check("br_pc_we", pc_we_o, 1);
            check("br_pc_sel", pc_sel_o, i != 1);
            check("br_alu", {alu_ctrl_o, alu_a_sel_o, alu_b_imm_o}, {5'd2, 2'd1, 1'b1});
            check("br_reg_we", reg_we_o, 0);
            step();
            check("br_back_fetch", {imem_req_o, pc_we_o, reg_we_o}, 3'b100);
        end
        // JAL x1,0
        fetch(32'h000000EF);
        exec(5'd2, 2'd1, 1'b1);
        step();
        wb(1'b1, 2'd2, 1'b1);
        // Async reset in the middle of MEM
        fetch(32'h0080A203);
        step();
        check("mid_mem_req", dmem_req_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_dmem", dmem_req_o, 0);
        check("rst_async_outs", {imem_req_o, reg_we_o, pc_we_o, alu_ctrl_o}, 0);
        check("rst_async_instr", instr_out_o, 0);
        step();
        rst_n = 1'b1;
        #1;
        check("post_rst_fetch", imem_req_o, 1);
        // Illegal opcode traps until reset
        fetch(32'h0000007F);
        check("trap_illegal", illegal_o, 1);
        imem_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("trap_quiet", {imem_req_o, dmem_req_o, reg_we_o, pc_we_o}, 0);
            step();
        end
        imem_ack_i = 1'b0;
        check("trap_sticky", illegal_o, 1);
        rst_n = 1'b0;
        #1;
        check("trap_rst_clear", illegal_o, 0);
        step();
        rst_n = 1'b1;
        #1;
        check("trap_exit_fetch", imem_req_o, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
